aes_avalon_host: RTL and testbench

- Avalon-MM initiator that drives the AES decryption peripheral's 16-word register map from a 128-bit command/response stream.
- Accepts key plus ciphertext, writes them to the peripheral, and sets START.
- Polls DONE, reads the four plaintext words back, clears START, and returns the plaintext.
- Sits between a local controller (or test harness) and the peripheral's Avalon-MM slave port.

---
 rtl/aes_avalon_host.sv | 181 ++++++++++++++++++
 tb/tb_aes_avalon_host.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_avalon_host.sv
// Avalon-MM initiator that runs one AES decrypt job on the peripheral register map.
// Define AES_HOST_TIMEOUT_EN to abort after POLL_LIMIT zero DONE polls (RSP_ERR=1).
module aes_avalon_host #(
  parameter int POLL_GAP   = 4,
  parameter int POLL_LIMIT = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_valid_i,
  output logic         cmd_ready_o,
  input  logic [127:0] cmd_key_i,
  input  logic [127:0] cmd_msg_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         avm_cs_o,
  output logic         avm_read_o,
  output logic         avm_write_o,
  output logic [3:0]   avm_addr_o,
  output logic [3:0]   avm_byte_en_o,
  output logic [31:0]  avm_writedata_o,
  input  logic [31:0]  avm_readdata_i,
  input  logic         avm_waitrequest_i
);
  typedef enum logic [3:0] {
    IDLE, WR_KEY, WR_MSG, WR_START, POLL, GAP, RD_DEC, WR_CLR, RESP
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d, msg_q, msg_d, data_q, data_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [31:0]  gap_q, gap_d;
  logic         live_q;
  logic         done;
`ifdef AES_HOST_TIMEOUT_EN
  logic [31:0]  poll_q, poll_d;
  logic         err_q, err_d;
`endif

  // Outputs are decoded from state so an async reset drops the bus at once.
  always_comb begin
    state_d         = state_q;
    key_d           = key_q;
    msg_d           = msg_q;
    data_d          = data_q;
    cnt_d           = cnt_q;
    gap_d           = gap_q;
    cmd_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    avm_cs_o        = 1'b0;
    avm_read_o      = 1'b0;
    avm_write_o     = 1'b0;
    avm_addr_o      = 4'd0;
    avm_writedata_o = 32'd0;
`ifdef AES_HOST_TIMEOUT_EN
    poll_d          = poll_q;
    err_d           = err_q;
`endif
    done            = ~avm_waitrequest_i;
    case (state_q)
      IDLE: begin
        cmd_ready_o = live_q;
        if (cmd_valid_i && live_q) begin
          key_d   = cmd_key_i;
          msg_d   = cmd_msg_i;
          cnt_d   = 2'd0;
          state_d = WR_KEY;
`ifdef AES_HOST_TIMEOUT_EN
          poll_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end
      WR_KEY, WR_MSG: begin
        avm_cs_o        = 1'b1;
        avm_write_o     = 1'b1;
        avm_addr_o      = {1'b0, state_q == WR_MSG, cnt_q};
        // word 0 is the most significant 32 bits
        avm_writedata_o = (state_q == WR_MSG) ? msg_q[{~cnt_q, 5'd0} +: 32]
                                              : key_q[{~cnt_q, 5'd0} +: 32];
        if (done) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = (state_q == WR_MSG) ? WR_START : WR_MSG;
        end
      end
      WR_START: begin
        avm_cs_o        = 1'b1;
        avm_write_o     = 1'b1;
        avm_addr_o      = 4'd14;
        avm_writedata_o = 32'd1;
        if (done) state_d = POLL;
      end
      POLL: begin
        avm_cs_o   = 1'b1;
        avm_read_o = 1'b1;
        avm_addr_o = 4'd15;
        if (done) begin
          if (avm_readdata_i != 32'd0) begin
            cnt_d   = 2'd0;
            state_d = RD_DEC;
          end else begin
            gap_d   = '0;
            state_d = (POLL_GAP == 0) ? POLL : GAP;
`ifdef AES_HOST_TIMEOUT_EN
            poll_d  = poll_q + 32'd1;
            if (poll_q == 32'(POLL_LIMIT - 1)) begin
              data_d  = '0;
              err_d   = 1'b1;
              state_d = WR_CLR;
            end
`endif
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 32'd1;
        if (gap_q == 32'(POLL_GAP - 1)) state_d = POLL;
      end
      RD_DEC: begin
        avm_cs_o   = 1'b1;
        avm_read_o = 1'b1;
        avm_addr_o = {2'b10, cnt_q};
        if (done) begin
          data_d[{cnt_q, 5'd0} +: 32] = avm_readdata_i;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WR_CLR;
        end
      end
      WR_CLR: begin
        avm_cs_o    = 1'b1;
        avm_write_o = 1'b1;
        avm_addr_o  = 4'd14;
        if (done) state_d = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    avm_byte_en_o = avm_cs_o ? 4'hf : 4'h0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      msg_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      msg_q   <= msg_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      live_q  <= 1'b1;
    end
  end

`ifdef AES_HOST_TIMEOUT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      poll_q <= '0;
      err_q  <= 1'b0;
    end else begin
      poll_q <= poll_d;
      err_q  <= err_d;
    end
  end
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  assign rsp_data_o = data_q;
endmodule

// File: tb/tb_aes_avalon_host.sv
// Directed bench for aes_avalon_host: a behavioural register-map slave on u0
// (POLL_GAP=4) and a trivial always-ready slave on u1 (POLL_GAP=0).
module tb_aes_avalon_host;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic         cmd_valid = 1'b0, rsp_ready = 1'b1;
  logic         cmd_ready, rsp_valid, rsp_err;
  logic [127:0] cmd_key = '0, cmd_msg = '0, rsp_data;
  logic         cs, rd, wr, wreq;
  logic [3:0]   addr, be;
  logic [31:0]  wdata, rdata;

  logic         c1_valid = 1'b0, r1_ready = 1'b1;
  logic         c1_ready, r1_valid, r1_err;
  logic [127:0] r1_data;
  logic         cs1, rd1, wr1;
  logic [3:0]   addr1, be1;
  logic [31:0]  wdata1, rdata1;

  aes_avalon_host #(.POLL_GAP(4), .POLL_LIMIT(8)) u0 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_key_i(cmd_key), .cmd_msg_i(cmd_msg), .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .avm_cs_o(cs), .avm_read_o(rd), .avm_write_o(wr), .avm_addr_o(addr),
    .avm_byte_en_o(be), .avm_writedata_o(wdata), .avm_readdata_i(rdata),
    .avm_waitrequest_i(wreq));

  aes_avalon_host #(.POLL_GAP(0), .POLL_LIMIT(8)) u1 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(c1_valid), .cmd_ready_o(c1_ready),
    .cmd_key_i(128'h1), .cmd_msg_i(128'h2), .rsp_valid_o(r1_valid),
    .rsp_ready_i(r1_ready), .rsp_data_o(r1_data), .rsp_err_o(r1_err),
    .avm_cs_o(cs1), .avm_read_o(rd1), .avm_write_o(wr1), .avm_addr_o(addr1),
    .avm_byte_en_o(be1), .avm_writedata_o(wdata1), .avm_readdata_i(rdata1),
    .avm_waitrequest_i(1'b0));

  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MSG = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;

  // slave model state for u0
  int          cyc = 0, log_n = 0, pcnt = 0, wcnt = 0, stab_err = 0, be_err = 0;
  int          rw_both = 0, wr14 = 0, stall_cyc = 0, rw1 = 0;
  int          done_at = 1;
  logic        stall_en = 1'b0, clr = 1'b0, held = 1'b0;
  logic [42:0] snap = '0;
  logic [36:0] log_e [64];
  int          log_c [64];

  assign wreq = stall_en && cs && (wcnt != 3) &&
                ((wr && addr == 4'd2) || (rd && addr == 4'd9));
  assign rdata1 = (addr1 == 4'd15) ? 32'd1 : {28'd0, addr1};

  always_comb begin
    rdata = '0;
    case (addr)
      4'd8:  rdata = 32'hccddeeff;
      4'd9:  rdata = 32'h8899aabb;
      4'd10: rdata = 32'h44556677;
      4'd11: rdata = 32'h00112233;
      4'd15: rdata = {31'd0, (done_at != 0) && (pcnt + 1 >= done_at)};
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if ((rd1 && wr1) || (cs1 && be1 != 4'hf) || (!cs1 && (be1 != 4'h0 || wdata1 != 32'd0)))
      rw1 <= rw1 + 1;
  end

  always @(posedge clk) begin
    if (clr) begin
      log_n <= 0; pcnt <= 0; wcnt <= 0; stab_err <= 0; be_err <= 0;
      rw_both <= 0; wr14 <= 0; stall_cyc <= 0; held <= 1'b0;
    end else begin
      if (rd && wr) rw_both <= rw_both + 1;
      if ((cs && be != 4'hf) || (!cs && be != 4'h0)) be_err <= be_err + 1;
      if (held && {cs, rd, wr, addr, be, wdata} != snap) stab_err <= stab_err + 1;
      held <= wreq;
      snap <= {cs, rd, wr, addr, be, wdata};
      if (wreq) begin
        wcnt <= wcnt + 1;
        stall_cyc <= stall_cyc + 1;
      end
      if (cs && (rd || wr) && !wreq) begin
        wcnt <= 0;
        if (log_n < 64) begin
          log_e[log_n[5:0]] <= {wr, addr, wr ? wdata : rdata};
          log_c[log_n[5:0]] <= cyc;
        end
        log_n <= log_n + 1;
        if (rd && addr == 4'd15) pcnt <= pcnt + 1;
        if (wr && addr == 4'd14) wr14 <= wr14 + 1;
      end
    end
  end

  int npass = 0, nfail = 0, nchk = 0, acc_cyc = 0, lat = 0, bad = 0;
  logic [36:0] exp_log [17] = '{
    {1'b1, 4'd0,  32'h00010203}, {1'b1, 4'd1,  32'h04050607},
    {1'b1, 4'd2,  32'h08090a0b}, {1'b1, 4'd3,  32'h0c0d0e0f},
    {1'b1, 4'd4,  32'h69c4e0d8}, {1'b1, 4'd5,  32'h6a7b0430},
    {1'b1, 4'd6,  32'hd8cdb780}, {1'b1, 4'd7,  32'h70b4c55a},
    {1'b1, 4'd14, 32'h00000001}, {1'b0, 4'd15, 32'h00000000},
    {1'b0, 4'd15, 32'h00000000}, {1'b0, 4'd15, 32'h00000001},
    {1'b0, 4'd8,  32'hccddeeff}, {1'b0, 4'd9,  32'h8899aabb},
    {1'b0, 4'd10, 32'h44556677}, {1'b0, 4'd11, 32'h00112233},
    {1'b1, 4'd14, 32'h00000000}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] m);
    int t = 0;
    @(negedge clk);
    cmd_key = k; cmd_msg = m; cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    check("cmd_accept", 128'(cmd_ready), 128'd1);
    @(negedge clk);
    acc_cyc = cyc; cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int t = 0;
    while (!rsp_valid && t < 400) begin @(negedge clk); t++; end
    check("rsp_valid", 128'(rsp_valid), 128'd1);
    lat = cyc - acc_cyc;
  endtask

  initial begin
    // reset state
    #1;
    check("rst_ready", 128'(cmd_ready), 128'd0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, '0);
    check("rst_avm", 128'({cs, rd, wr, addr, be, wdata}), 128'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 128'(cmd_ready), 128'd1);

    // FIPS-197 vector, DONE on 3rd poll
    do_clr(); done_at = 3;
    send(KEY, MSG);
    wait_rsp();
    check("fips_data", rsp_data, PT);
    check("fips_err", 128'(rsp_err), 128'd0);
    check("fips_count", 128'(log_n), 128'd17);
    for (int i = 0; i < 17; i++) check($sformatf("fips_log%0d", i), 128'(log_e[i]), 128'(exp_log[i]));
    check("gap1", 128'(log_c[10] - log_c[9]), 128'd5);
    check("gap2", 128'(log_c[11] - log_c[10]), 128'd5);
    check("fips_proto", 128'(rw_both + be_err), 128'd0);

    // waitrequest stalls on addr-2 write and addr-9 read
    do_clr(); done_at = 1; stall_en = 1'b1;
    send(KEY, MSG);
    wait_rsp();
    stall_en = 1'b0;
    check("stall_count", 128'(log_n), 128'd15);
    check("stall_cycles", 128'(stall_cyc), 128'd6);
    check("stall_stable", 128'(stab_err), 128'd0);
    for (int i = 0; i < 9; i++) check($sformatf("stall_log%0d", i), 128'(log_e[i]), 128'(exp_log[i]));
    check("stall_poll", 128'(log_e[9]), 128'({1'b0, 4'd15, 32'd1}));
    for (int i = 10; i < 15; i++) check($sformatf("stall_log%0d", i), 128'(log_e[i]), 128'(exp_log[i + 2]));
    check("stall_data", rsp_data, PT);

    // async reset mid-WR_MSG
    do_clr(); done_at = 1;
    send(KEY, MSG);
    begin
      int t = 0;
      while (log_n < 6 && t < 50) begin @(negedge clk); t++; end
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_avm", 128'({cs, rd, wr, addr, be, wdata}), 128'd0);
    check("mid_rst_rsp", 128'(rsp_valid), 128'd0);
    check("mid_rst_ready", 128'(cmd_ready), 128'd0);
    @(negedge clk);
    check("mid_rst_ready2", 128'(cmd_ready), 128'd0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    check("post_rst_ready", 128'(cmd_ready), 128'd1);
    check("post_rst_no_clr", 128'(wr14), 128'd0);
    check("post_rst_count", 128'(log_n), 128'd6);

    // response backpressure, ignored command, then a second command
    do_clr(); done_at = 1; rsp_ready = 1'b0;
    send(KEY, MSG);
    wait_rsp();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!(rsp_valid === 1'b1 && rsp_data === PT && cmd_ready === 1'b0)) bad++;
      if (i == 3) begin cmd_key = '1; cmd_valid = 1'b1; end
      if (i == 4) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("bp_stable", 128'(bad), 128'd0);
    check("bp_no_xfer", 128'(log_n), 128'd15);
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", 128'({rsp_valid, cmd_ready}), 128'b01);
    check("bp_hs_hold", rsp_data, PT);
    do_clr();
    send('1, MSG);
    wait_rsp();
    for (int i = 0; i < 4; i++) check($sformatf("key2_log%0d", i), 128'(log_e[i]), 128'({1'b1, 4'(i), 32'hffffffff}));
    check("key2_msg", 128'(log_e[4]), 128'(exp_log[4]));
    check("key2_data", rsp_data, PT);

`ifdef AES_HOST_TIMEOUT_EN
    // DONE never set: abort after POLL_LIMIT=8 polls
    do_clr(); done_at = 0;
    send(KEY, MSG);
    wait_rsp();
    check("to_count", 128'(log_n), 128'd18);
    check("to_polls", 128'(pcnt), 128'd8);
    check("to_last_poll", 128'(log_e[16]), 128'({1'b0, 4'd15, 32'd0}));
    check("to_clr", 128'(log_e[17]), 128'({1'b1, 4'd14, 32'd0}));
    check("to_err", 128'(rsp_err), 128'd1);
    check("to_data", rsp_data, 128'd0);
    do_clr(); done_at = 1;
    send(KEY, MSG);
    wait_rsp();
    check("to_err_clear", 128'(rsp_err), 128'd0);
    check("to_after_data", rsp_data, PT);
`endif

    // POLL_GAP=0 instance: minimum latency
    @(negedge clk);
    check("u1_ready", 128'(c1_ready), 128'd1);
    c1_valid = 1'b1;
    @(negedge clk);
    acc_cyc = cyc; c1_valid = 1'b0;
    begin
      int t = 0;
      while (!r1_valid && t < 100) begin @(negedge clk); t++; end
    end
    check("u1_valid", 128'(r1_valid), 128'd1);
    check("u1_latency", 128'(cyc - acc_cyc), 128'd15);
    check("u1_data", r1_data, {32'hb, 32'ha, 32'h9, 32'h8});
    check("u1_err", 128'(r1_err), 128'd0);
    check("u1_proto", 128'(rw1), 128'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
